decode_ctrl_stage: RTL and testbench

Registered main-control stage of the RISC-V pipeline: decodes the ID-stage opcode into the control bundle and holds it in the ID/EX control register. It detects load-use hazards and inserts bubbles, and squashes on taken branches or jumps. It also sequences multi-cycle M-extension operations by stalling the front end for a parametrised latency. It sits between the IF/ID register and the EX stage and drives the PC/IF-ID stall line.

---
 rtl/decode_ctrl_stage_if.sv | 53 +++++
 rtl/decode_ctrl_stage.sv | 169 ++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_stage_if
//  Description : Bundle of ID-stage inputs, branch squash, stall/md_done and
//                the registered ID/EX control outputs of decode_ctrl_stage.
//                The master modport belongs to the surrounding pipeline and
//                the slave modport belongs to the control stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_ctrl_stage_if;
  // ID-stage instruction fields
  logic       id_valid;
  logic [6:0] id_opcode;
  logic       id_funct7_b0;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  // Branch/jump resolved taken in EX
  logic       ex_flush;
  // Stage status
  logic       stall;
  logic       md_done;
  // ID/EX control register
  logic       ex_valid;
  logic       ex_alusrc;
  logic       ex_memtoreg;
  logic       ex_regwrite;
  logic       ex_memread;
  logic       ex_memwrite;
  logic       ex_branch;
  logic       ex_jalrsel;
  logic       ex_jump;
  logic       ex_lui;
  logic       ex_auipc;
  logic       ex_md;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rd;

  modport master (
    output id_valid, id_opcode, id_funct7_b0, id_rs1, id_rs2, id_rd, ex_flush,
    input  stall, md_done,
    input  ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
    input  ex_branch, ex_jalrsel, ex_jump, ex_lui, ex_auipc, ex_md, ex_aluop, ex_rd
  );

  modport slave (
    input  id_valid, id_opcode, id_funct7_b0, id_rs1, id_rs2, id_rd, ex_flush,
    output stall, md_done,
    output ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
    output ex_branch, ex_jalrsel, ex_jump, ex_lui, ex_auipc, ex_md, ex_aluop, ex_rd
  );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_stage
//  Description : Main-control decode with ID/EX control register, load-use
//                bubble insertion, branch/jump squash and multi-cycle
//                M-extension sequencing (front-end stall for MD_LATENCY).
//                Optional feature macro: DECODE_CTRL_MULDIV_EN
//                  defined   -> M-op detection, busy counter, md_done
//                  undefined -> M opcodes behave as plain 1-cycle R-type
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_stage #(
  parameter int MD_LATENCY = 4      // cycles an M op occupies EX, 1..16
) (
  input  wire logic           clk,
  input  wire logic           reset,
  decode_ctrl_stage_if.slave  bus
);

  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jalrsel;
    logic       jump;
    logic       lui;
    logic       auipc;
    logic       md;
    logic [1:0] aluop;
    logic [4:0] rd;
  } ctrl_t;

  localparam ctrl_t c_BUBBLE = '0;

  logic  w_is_r, w_is_load, w_is_store, w_is_br, w_is_i;
  logic  w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;
  logic  w_known, w_rs2_used, w_md_bit, w_load_use, w_md_busy;
  ctrl_t w_dec;
  ctrl_t r_ctrl;

  assign w_is_r     = (bus.id_opcode == c_OP_R);
  assign w_is_load  = (bus.id_opcode == c_OP_LOAD);
  assign w_is_store = (bus.id_opcode == c_OP_STORE);
  assign w_is_br    = (bus.id_opcode == c_OP_BR);
  assign w_is_i     = (bus.id_opcode == c_OP_I);
  assign w_is_jal   = (bus.id_opcode == c_OP_JAL);
  assign w_is_jalr  = (bus.id_opcode == c_OP_JALR);
  assign w_is_lui   = (bus.id_opcode == c_OP_LUI);
  assign w_is_auipc = (bus.id_opcode == c_OP_AUIPC);

  assign w_known    = w_is_r | w_is_load | w_is_store | w_is_br | w_is_i |
                      w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
  assign w_rs2_used = w_is_r | w_is_store | w_is_br;

`ifdef DECODE_CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(MD_LATENCY + 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_md_bit    = bus.id_funct7_b0;
  assign w_md_busy   = (r_cnt != '0);
  assign bus.md_done = r_ctrl.valid & r_ctrl.md & (r_cnt == '0);

  // Busy counter: IDLE when zero; an M op entering EX preloads the remaining
  // occupancy, then it counts down while the front end is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (bus.ex_flush) begin
      r_cnt <= '0;
    end else if (w_md_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (!w_load_use && w_dec.md) begin
      r_cnt <= CNT_W'(MD_LATENCY - 1);
    end
  end
`else
  logic w_unused;

  // funct7 bit 0 and the latency are meaningless without the M unit
  assign w_unused    = ^{bus.id_funct7_b0, MD_LATENCY};
  assign w_md_bit    = 1'b0;
  assign w_md_busy   = 1'b0;
  assign bus.md_done = 1'b0;
`endif

  // Load-use: the load now in EX writes a register this ID instruction reads
  assign w_load_use = bus.id_valid & r_ctrl.valid & r_ctrl.memread &
                      (r_ctrl.rd != 5'd0) &
                      ((r_ctrl.rd == bus.id_rs1) |
                       (w_rs2_used & (r_ctrl.rd == bus.id_rs2)));

  // Flush overrides every stall source so the squashed slot drains at once
  assign bus.stall = ~bus.ex_flush & (w_md_busy | w_load_use);

  // Opcode decode into the control bundle; invalid or unknown -> bubble
  always_comb begin
    w_dec = c_BUBBLE;
    if (bus.id_valid && w_known) begin
      w_dec.valid    = 1'b1;
      w_dec.alusrc   = w_is_load | w_is_store | w_is_i | w_is_jalr | w_is_lui | w_is_auipc;
      w_dec.regwrite = w_is_r | w_is_load | w_is_i | w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
      w_dec.memtoreg = w_is_load;
      w_dec.memread  = w_is_load;
      w_dec.memwrite = w_is_store;
      w_dec.branch   = w_is_br;
      w_dec.jump     = w_is_jal;
      w_dec.jalrsel  = w_is_jalr;
      w_dec.lui      = w_is_lui;
      w_dec.auipc    = w_is_auipc;
      w_dec.md       = w_is_r & w_md_bit;
      w_dec.rd       = bus.id_rd;
      if (w_is_br)
        w_dec.aluop = 2'b01;
      else if (w_is_r || w_is_i)
        w_dec.aluop = 2'b10;
      else if (w_is_lui || w_is_auipc)
        w_dec.aluop = 2'b11;
      else
        w_dec.aluop = 2'b00;
    end
  end

  // ID/EX control register: reset, flush, M-op hold, load-use bubble, decode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= c_BUBBLE;
    end else if (bus.ex_flush) begin
      r_ctrl <= c_BUBBLE;
    end else if (w_md_busy) begin
      r_ctrl <= r_ctrl;
    end else if (w_load_use) begin
      r_ctrl <= c_BUBBLE;
    end else begin
      r_ctrl <= w_dec;
    end
  end

  assign bus.ex_valid    = r_ctrl.valid;
  assign bus.ex_alusrc   = r_ctrl.alusrc;
  assign bus.ex_memtoreg = r_ctrl.memtoreg;
  assign bus.ex_regwrite = r_ctrl.regwrite;
  assign bus.ex_memread  = r_ctrl.memread;
  assign bus.ex_memwrite = r_ctrl.memwrite;
  assign bus.ex_branch   = r_ctrl.branch;
  assign bus.ex_jalrsel  = r_ctrl.jalrsel;
  assign bus.ex_jump     = r_ctrl.jump;
  assign bus.ex_lui      = r_ctrl.lui;
  assign bus.ex_auipc    = r_ctrl.auipc;
  assign bus.ex_md       = r_ctrl.md;
  assign bus.ex_aluop    = r_ctrl.aluop;
  assign bus.ex_rd       = r_ctrl.rd;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_ctrl_stage
//  Description : Self-checking bench for decode_ctrl_stage: directed hazard,
//                M-op and flush sequences followed by random instruction
//                streams compared against an instruction-level EX-slot model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_stage;

  localparam int LAT = 4;
`ifdef DECODE_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int EXP_MUL_STALLS = MD_EN ? LAT - 1 : 0;
  localparam int EXP_DONE_AT    = MD_EN ? LAT : 0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Expected EX-slot content, packed in the order the bench reads the DUT
  typedef struct packed {
    logic       valid, alusrc, memtoreg, regwrite, memread, memwrite;
    logic       branch, jalrsel, jump, lui, auipc, md;
    logic [1:0] aluop;
    logic [4:0] rd;
  } slot_t;

  logic clk;
  logic reset;
  decode_ctrl_stage_if bus ();

  decode_ctrl_stage #(.MD_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  slot_t m_ex;        // instruction the model believes is in EX
  int    m_age;       // cycles that instruction has spent in EX
  logic  obs_stall;
  logic  obs_done;
  logic  last_stall;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic slot_t dut_slot();
    return {bus.ex_valid, bus.ex_alusrc, bus.ex_memtoreg, bus.ex_regwrite,
            bus.ex_memread, bus.ex_memwrite, bus.ex_branch, bus.ex_jalrsel,
            bus.ex_jump, bus.ex_lui, bus.ex_auipc, bus.ex_md,
            bus.ex_aluop, bus.ex_rd};
  endfunction

  // Control bundle an instruction should carry, from the opcode tables
  function automatic slot_t ref_decode(input logic v, input logic [6:0] op,
                                       input logic f7, input logic [4:0] rd);
    slot_t s;
    s = '0;
    if (v && (op inside {OP_R, OP_LOAD, OP_STORE, OP_BR, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})) begin
      s.valid    = 1'b1;
      s.alusrc   = op inside {OP_LOAD, OP_STORE, OP_I, OP_JALR, OP_LUI, OP_AUIPC};
      s.regwrite = op inside {OP_R, OP_LOAD, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      s.memtoreg = (op == OP_LOAD);
      s.memread  = (op == OP_LOAD);
      s.memwrite = (op == OP_STORE);
      s.branch   = (op == OP_BR);
      s.jump     = (op == OP_JAL);
      s.jalrsel  = (op == OP_JALR);
      s.lui      = (op == OP_LUI);
      s.auipc    = (op == OP_AUIPC);
      s.md       = MD_EN && (op == OP_R) && f7;
      s.aluop    = (op inside {OP_R, OP_I})       ? 2'b10 :
                   (op == OP_BR)                  ? 2'b01 :
                   (op inside {OP_LUI, OP_AUIPC}) ? 2'b11 : 2'b00;
      s.rd       = rd;
    end
    return s;
  endfunction

  // One pipeline cycle: drive ID, check the combinational and registered
  // outputs against the model, clock, then advance the model.
  task automatic step(input logic rst, input logic v, input logic [6:0] op,
                      input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic flush);
    logic  lu, md_hold, e_stall, e_done;
    reset = rst;
    bus.id_valid = v;  bus.id_opcode = op;  bus.id_funct7_b0 = f7;
    bus.id_rs1 = rs1;  bus.id_rs2 = rs2;    bus.id_rd = rd;
    bus.ex_flush = flush;
    #4;
    lu      = v && m_ex.valid && m_ex.memread && (m_ex.rd != 0) &&
              ((m_ex.rd == rs1) || ((op inside {OP_R, OP_STORE, OP_BR}) && m_ex.rd == rs2));
    md_hold = m_ex.md && (m_age < LAT);
    e_stall = !flush && (md_hold || lu);
    e_done  = m_ex.valid && m_ex.md && (m_age >= LAT);
    obs_stall = bus.stall;
    obs_done  = bus.md_done;
    check_val("ex_bundle", 32'(dut_slot()), 32'(m_ex));
    check_val("stall", 32'(obs_stall), 32'(e_stall));
    check_val("md_done", 32'(obs_done), 32'(e_done));
    last_stall = e_stall;
    @(posedge clk);
    if (rst || flush) begin
      m_ex = '0;  m_age = 0;
    end else if (md_hold) begin
      m_age++;
    end else if (lu) begin
      m_ex = '0;  m_age = 0;
    end else begin
      m_ex = ref_decode(v, op, f7, rd);  m_age = 1;
    end
    #1;
  endtask

  initial begin
    int n_st, done_at, seen_done;
    logic [6:0] ops [10];
    logic       r_v, r_f7;
    logic [6:0] r_op;
    logic [4:0] r_rs1, r_rs2, r_rd;
    ops = '{OP_R, OP_LOAD, OP_STORE, OP_BR, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b1111111};
    m_ex = '0;  m_age = 0;  last_stall = 1'b0;
    reset = 1'b1;
    bus.id_valid = 1'b1;  bus.id_opcode = OP_R;  bus.id_funct7_b0 = 1'b0;
    bus.id_rs1 = 5'd1;    bus.id_rs2 = 5'd2;     bus.id_rd = 5'd3;
    bus.ex_flush = 1'b0;
    @(posedge clk); #1;

    // Reset held with a live R-type in ID, then the R-type is captured
    step(1, 1, OP_R, 0, 1, 2, 3, 0);
    step(1, 1, OP_R, 0, 1, 2, 3, 0);
    step(0, 1, OP_R, 0, 1, 2, 3, 0);
    check_val("rel_regwrite", 32'(bus.ex_regwrite), 32'd1);
    check_val("rel_aluop", 32'(bus.ex_aluop), 32'd2);

    // LOAD x5 then ADD using x5: one bubble, ADD in EX two cycles after LOAD
    step(0, 1, OP_LOAD, 0, 1, 0, 5, 0);
    step(0, 1, OP_R, 0, 5, 6, 7, 0);
    check_val("lu_stall", 32'(obs_stall), 32'd1);
    check_val("lu_bubble", 32'(bus.ex_valid), 32'd0);
    step(0, 1, OP_R, 0, 5, 6, 7, 0);
    check_val("lu_released", 32'(obs_stall), 32'd0);
    check_val("lu_add_in_ex", 32'({bus.ex_valid, bus.ex_rd}), 32'({1'b1, 5'd7}));

    // Load to x0 never creates a hazard
    step(0, 1, OP_LOAD, 0, 1, 0, 0, 0);
    step(0, 1, OP_R, 0, 0, 0, 7, 0);
    check_val("lu_x0", 32'(obs_stall), 32'd0);

    // STORE reads rs2; I-type does not
    step(0, 1, OP_LOAD, 0, 1, 0, 5, 0);
    step(0, 1, OP_STORE, 0, 1, 5, 0, 0);
    check_val("lu_store_rs2", 32'(obs_stall), 32'd1);
    step(0, 1, OP_STORE, 0, 1, 5, 0, 0);
    step(0, 1, OP_LOAD, 0, 1, 0, 5, 0);
    step(0, 1, OP_I, 0, 1, 5, 8, 0);
    check_val("lu_itype_rs2", 32'(obs_stall), 32'd0);

    // MUL: stall for LAT-1 cycles, md_done on the last EX cycle
    step(0, 1, OP_R, 1, 1, 2, 3, 0);
    check_val("mul_aluop", 32'(bus.ex_aluop), 32'd2);
    n_st = 0;  done_at = 0;
    for (int k = 0; k < LAT; k++) begin
      step(0, 1, OP_R, 0, 6, 7, 8, 0);
      n_st += int'(obs_stall);
      if (obs_done) done_at = k + 1;
    end
    check_val("mul_stalls", 32'(n_st), 32'(EXP_MUL_STALLS));
    check_val("mul_done_at", 32'(done_at), 32'(EXP_DONE_AT));

    // Flush on the second busy cycle of a MUL aborts it
    step(0, 1, OP_R, 1, 1, 2, 3, 0);
    seen_done = 0;
    step(0, 1, OP_R, 0, 6, 7, 8, 0);
    seen_done += int'(obs_done);
    step(0, 1, OP_R, 0, 6, 7, 8, 1);
    check_val("flush_stall", 32'(obs_stall), 32'd0);
    check_val("flush_bubble", 32'(bus.ex_valid), 32'd0);
    for (int k = 0; k < LAT; k++) begin
      step(0, 1, OP_I, 0, 9, 9, 9, 0);
      seen_done += int'(obs_done);
    end
    check_val("flush_no_done", 32'(seen_done), 32'd0);

    // Random streams; ID is held while the model expects a stall
    r_v = 1'b1;  r_op = OP_R;  r_f7 = 1'b0;  r_rs1 = 0;  r_rs2 = 0;  r_rd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        r_v   = ($urandom_range(0, 9) != 0);
        r_op  = ops[$urandom_range(0, 9)];
        r_f7  = 1'($urandom);
        r_rs1 = 5'($urandom_range(0, 3));
        r_rs2 = 5'($urandom_range(0, 3));
        r_rd  = 5'($urandom_range(0, 3));
      end
      step(($urandom_range(0, 79) == 0), r_v, r_op, r_f7, r_rs1, r_rs2, r_rd,
           ($urandom_range(0, 11) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
